stopwatch_time_counter: RTL and testbench



---
 rtl/stopwatch_time_counter.sv | 189 ++++++++++++++++++
 tb/tb_stopwatch_time_counter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_time_counter.sv
// Stopwatch run control, 100 Hz prescaler and HH:MM:SS.cc BCD counter.
// The lap snapshot and display freeze are built only when STOPWATCH_LAP_EN is defined.
module stopwatch_time_counter #(
  parameter int unsigned CLK_HZ  = 100_000_000,
  parameter int unsigned TICK_HZ = 100,
  parameter int unsigned HR_MAX  = 23
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start_stop,
  input  logic       i_lap,
  input  logic       i_clear,
  output logic [3:0] o_hr_t,
  output logic [3:0] o_hr_u,
  output logic [3:0] o_min_t,
  output logic [3:0] o_min_u,
  output logic [3:0] o_sec_t,
  output logic [3:0] o_sec_u,
  output logic [3:0] o_cs_t,
  output logic [3:0] o_cs_u,
  output logic       o_running,
  output logic       o_lap_hold,
  output logic       o_wrap
);

  localparam int unsigned DIV = CLK_HZ / TICK_HZ;
  localparam int unsigned PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PLast = PW'(DIV - 1);
  localparam logic [3:0] HrMaxT = 4'(HR_MAX / 10);
  localparam logic [3:0] HrMaxU = 4'(HR_MAX % 10);

  typedef struct packed {
    logic [3:0] hr_t;
    logic [3:0] hr_u;
    logic [3:0] min_t;
    logic [3:0] min_u;
    logic [3:0] sec_t;
    logic [3:0] sec_u;
    logic [3:0] cs_t;
    logic [3:0] cs_u;
  } digits_t;

  typedef enum logic [1:0] {StIdle, StRun, StPause} state_e;

  state_e         state_q, state_d;
  logic [PW-1:0]  presc_q, presc_d;
  digits_t        cnt_q, cnt_d, adv, disp_d;
  logic           adv_wrap, wrap_d, carry;
  logic           hold_q, hold_d;

`ifdef STOPWATCH_LAP_EN
  digits_t        snap_q, snap_d;
`else
  logic           unused_lap;
  assign unused_lap = i_lap;
`endif

  // Count value one tick ahead; only used when the prescaler is at its last step.
  always_comb begin
    adv      = cnt_q;
    adv_wrap = 1'b0;
    carry    = (presc_q == PLast);
    if (carry) begin
      if (adv.cs_u == 4'd9) adv.cs_u = '0;
      else begin adv.cs_u = adv.cs_u + 4'd1; carry = 1'b0; end
    end
    if (carry) begin
      if (adv.cs_t == 4'd9) adv.cs_t = '0;
      else begin adv.cs_t = adv.cs_t + 4'd1; carry = 1'b0; end
    end
    if (carry) begin
      if (adv.sec_u == 4'd9) adv.sec_u = '0;
      else begin adv.sec_u = adv.sec_u + 4'd1; carry = 1'b0; end
    end
    if (carry) begin
      if (adv.sec_t == 4'd5) adv.sec_t = '0;
      else begin adv.sec_t = adv.sec_t + 4'd1; carry = 1'b0; end
    end
    if (carry) begin
      if (adv.min_u == 4'd9) adv.min_u = '0;
      else begin adv.min_u = adv.min_u + 4'd1; carry = 1'b0; end
    end
    if (carry) begin
      if (adv.min_t == 4'd5) adv.min_t = '0;
      else begin adv.min_t = adv.min_t + 4'd1; carry = 1'b0; end
    end
    if (carry) begin
      if (adv.hr_t == HrMaxT && adv.hr_u == HrMaxU) begin
        adv.hr_t = '0;
        adv.hr_u = '0;
        adv_wrap = 1'b1;
      end else if (adv.hr_u == 4'd9) begin
        adv.hr_u = '0;
        adv.hr_t = adv.hr_t + 4'd1;
      end else begin
        adv.hr_u = adv.hr_u + 4'd1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    wrap_d  = 1'b0;
`ifdef STOPWATCH_LAP_EN
    snap_d  = snap_q;
`endif
    // The count advances on every RUN edge, including the edge that pauses.
    if (state_q == StRun) begin
      presc_d = (presc_q == PLast) ? '0 : presc_q + 1'b1;
      cnt_d   = adv;
      wrap_d  = adv_wrap;
    end
    unique case (state_q)
      StIdle: begin
        if (i_start_stop) begin
          state_d = StRun;
          presc_d = '0;
        end
      end
      StRun: begin
        if (i_start_stop) begin
          state_d = StPause;
        end
`ifdef STOPWATCH_LAP_EN
        else if (i_lap) begin
          hold_d = ~hold_q;
          if (!hold_q) snap_d = cnt_q;
        end
`endif
      end
      StPause: begin
        if (i_clear) begin
          state_d = StIdle;
          presc_d = '0;
          cnt_d   = '0;
          hold_d  = 1'b0;
`ifdef STOPWATCH_LAP_EN
          snap_d  = '0;
`endif
        end else if (i_start_stop) begin
          state_d = StRun;
        end
`ifdef STOPWATCH_LAP_EN
        else if (i_lap && hold_q) begin
          hold_d = 1'b0;
        end
`endif
      end
      default: state_d = StIdle;
    endcase
`ifdef STOPWATCH_LAP_EN
    disp_d = hold_d ? snap_d : cnt_d;
`else
    disp_d = cnt_d;
`endif
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= StIdle;
      presc_q    <= '0;
      cnt_q      <= '0;
      hold_q     <= 1'b0;
`ifdef STOPWATCH_LAP_EN
      snap_q     <= '0;
`endif
      {o_hr_t, o_hr_u, o_min_t, o_min_u, o_sec_t, o_sec_u, o_cs_t, o_cs_u} <= '0;
      o_running  <= 1'b0;
      o_lap_hold <= 1'b0;
      o_wrap     <= 1'b0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      cnt_q      <= cnt_d;
      hold_q     <= hold_d;
`ifdef STOPWATCH_LAP_EN
      snap_q     <= snap_d;
`endif
      {o_hr_t, o_hr_u, o_min_t, o_min_u, o_sec_t, o_sec_u, o_cs_t, o_cs_u} <= disp_d;
      o_running  <= (state_d == StRun);
      o_lap_hold <= hold_d;
      o_wrap     <= wrap_d;
    end
  end

endmodule

// File: tb/tb_stopwatch_time_counter.sv
// Directed bench for stopwatch_time_counter with DIV=10; expectations go through a scoreboard queue.
module tb_stopwatch_time_counter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ss  = 1'b0;
  logic lap = 1'b0;
  logic clr = 1'b0;
  logic [3:0] hr_t, hr_u, min_t, min_u, sec_t, sec_u, cs_t, cs_u;
  logic running, lap_hold, wrap;

  stopwatch_time_counter #(
    .CLK_HZ (1000),
    .TICK_HZ(100),
    .HR_MAX (23)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_start_stop(ss),
    .i_lap       (lap),
    .i_clear     (clr),
    .o_hr_t      (hr_t),
    .o_hr_u      (hr_u),
    .o_min_t     (min_t),
    .o_min_u     (min_u),
    .o_sec_t     (sec_t),
    .o_sec_u     (sec_u),
    .o_cs_t      (cs_t),
    .o_cs_u      (cs_u),
    .o_running   (running),
    .o_lap_hold  (lap_hold),
    .o_wrap      (wrap)
  );

  always #5 clk = ~clk;

`ifdef STOPWATCH_LAP_EN
  localparam bit LapEn = 1'b1;
`else
  localparam bit LapEn = 1'b0;
`endif

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  function automatic logic [31:0] disp();
    return {hr_t, hr_u, min_t, min_u, sec_t, sec_u, cs_t, cs_u};
  endfunction

  function automatic logic [31:0] flags();
    return {29'd0, running, lap_hold, wrap};
  endfunction

  // Hundredths since 00:00:00.00 to packed BCD digits.
  function automatic logic [31:0] bcd(int n);
    int cs, s, m, h;
    n  = n % (24 * 360000);
    cs = n % 100;
    s  = (n / 100) % 60;
    m  = (n / 6000) % 60;
    h  = n / 360000;
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10),
            4'(s / 10), 4'(s % 10), 4'(cs / 10), 4'(cs % 10)};
  endfunction

  task automatic push(input string tag, input logic [31:0] e);
    exp_t x;
    x.tag = tag;
    x.exp = e;
    sb.push_back(x);
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t x;
    tests++;
    if (sb.size() == 0) begin
      fails++;
      $error("FAIL scoreboard_empty: got %h, no expected entry", obs);
    end else begin
      x = sb.pop_front();
      assert (obs === x.exp) else begin
        fails++;
        $error("FAIL %s: got %h required %h", x.tag, obs, x.exp);
      end
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_ss();
    ss = 1'b1; step(1); ss = 1'b0;
  endtask

  task automatic pulse_lap();
    lap = 1'b1; step(1); lap = 1'b0;
  endtask

  task automatic pulse_clr();
    clr = 1'b1; step(1); clr = 1'b0;
  endtask

  initial begin
    int wrapped;
    int changes;
    logic [31:0] prev;

    // Reset
    step(3);
    push("rst_digits", 32'h0);
    push("rst_flags", 32'h0);
    check(disp());
    check(flags());
    rst = 1'b0;
    step(1);

    // Start and first ticks
    push("start_running", 32'h4);
    pulse_ss();
    check(flags());
    push("pre_first_tick", bcd(0));
    step(9);
    check(disp());
    push("first_tick", bcd(1));
    step(1);
    check(disp());
    push("cs_t_carry", bcd(10));
    step(90);
    check(disp());

    // Seconds to minutes carry
    push("sec_59_99", bcd(5999));
    step(59890);
    check(disp());
    wrapped = 0;
    push("min_carry", bcd(6000));
    push("min_no_wrap", 32'h0);
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (wrap) wrapped = 1;
    end
    check(disp());
    check(32'(wrapped));

    // Pause 4 cycles after a tick; resume keeps prescaler fraction
    step(3);
    push("pause_flags", 32'h0);
    pulse_ss();
    check(flags());
    push("pause_hold", bcd(6000));
    step(50);
    check(disp());
    push("resume_flags", 32'h4);
    pulse_ss();
    check(flags());
    push("resume_pre_tick", bcd(6000));
    step(5);
    check(disp());
    push("resume_tick", bcd(6001));
    step(1);
    check(disp());

    // Clear in RUN is ignored
    push("run_clear_flags", 32'h4);
    push("run_clear_digits", bcd(6001));
    pulse_clr();
    check(flags());
    check(disp());
    push("run_clear_continues", bcd(6002));
    step(9);
    check(disp());

    // Clear with start_stop in PAUSE: clear wins
    pulse_ss();
    ss = 1'b1; clr = 1'b1;
    step(1);
    ss = 1'b0; clr = 1'b0;
    push("clr_digits", 32'h0);
    push("clr_flags", 32'h0);
    check(disp());
    check(flags());
    push("idle_holds", 32'h0);
    step(20);
    check(disp());

    // Lap freeze and release
    pulse_ss();
    step(1230);
    push("lap_pre", bcd(123));
    check(disp());
    push("lap_set_digits", bcd(123));
    push("lap_set_flags", LapEn ? 32'h6 : 32'h4);
    pulse_lap();
    check(disp());
    check(flags());
    changes = 0;
    prev = disp();
    for (int i = 0; i < 2000; i++) begin
      step(1);
      if (disp() !== prev) changes++;
      prev = disp();
    end
    push("lap_display_changes", LapEn ? 32'd0 : 32'd200);
    push("lap_frozen_digits", LapEn ? bcd(123) : bcd(323));
    check(32'(changes));
    check(disp());
    push("lap_release_digits", bcd(323));
    push("lap_release_flags", 32'h4);
    pulse_lap();
    check(disp());
    check(flags());

    // Hour wrap from 23:59:59.99, preloaded while paused
    pulse_ss();
    force dut.cnt_q = 32'h2359_5999;
    step(1);
    release dut.cnt_q;
    push("wrap_preload", 32'h2359_5999);
    check(disp());
    pulse_ss();
    for (int i = 0; i < 30; i++) begin
      if (disp() === 32'h0) break;
      step(1);
    end
    push("wrap_digits", 32'h0);
    push("wrap_pulse", 32'h1);
    check(disp());
    check(32'(wrap));
    step(1);
    push("wrap_one_cycle", 32'h0);
    check(32'(wrap));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
